// File: rtl/multicore_run_ctrl.sv
// Run/reset sequencer for an N-core cluster: holds every core in reset,
// releases them one at a time with a programmable stagger, then supervises
// the run until all cores halt or the cycle budget expires.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   start         run request, accepted only in IDLE or DONE
//   abort         return to IDLE from any state (beats start)
//   cycle_budget  max RUN cycles, 0 = unlimited, latched on accepted start
//   core_halted   per-core halt level from the cores
//   core_rst      per-core reset, active-high
//   running       high in RELEASE and RUN
//   done          high in DONE
//   timeout       high in DONE when the budget ran out
//   halted_mask   sticky per-core halted flags
//   cycle_count   RUN cycles elapsed, saturating
module multicore_run_ctrl #(
    parameter int NUM_CORES = 4,
    parameter int RST_HOLD  = 2,
    parameter int STAGGER   = 1,
    parameter int CYCLE_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CYCLE_W-1:0]   cycle_budget,
    input  logic [NUM_CORES-1:0] core_halted,
    output logic [NUM_CORES-1:0] core_rst,
    output logic                 running,
    output logic                 done,
    output logic                 timeout,
    output logic [NUM_CORES-1:0] halted_mask,
    output logic [CYCLE_W-1:0]   cycle_count
);

    localparam int REL_LEN = (NUM_CORES - 1) * STAGGER + 1;
    localparam int PH_MAX  = (RST_HOLD > REL_LEN) ? RST_HOLD : REL_LEN;
    localparam int PH_W    = $clog2(PH_MAX + 1);

    typedef enum logic [2:0] {IDLE, HOLD, RELEASE, RUN, DONE} state_t;

    state_t               state, state_d;
    logic [PH_W-1:0]      ph_cnt, ph_d;
    logic [CYCLE_W-1:0]   budget, budget_d;
    logic [CYCLE_W-1:0]   count_d;
    logic [NUM_CORES-1:0] mask_d;
    logic [NUM_CORES-1:0] core_rst_d;
    logic                 timeout_d;
    logic                 running_d;
    logic                 done_d;

    always_comb begin
        state_d   = state;
        ph_d      = ph_cnt;
        budget_d  = budget;
        count_d   = cycle_count;
        timeout_d = timeout;
        // A halt only counts once the core's registered reset is low.
        mask_d    = halted_mask | (core_halted & ~core_rst);

        if (abort) begin
            state_d   = IDLE;
            ph_d      = '0;
            mask_d    = '0;
            count_d   = '0;
            timeout_d = 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state_d   = HOLD;
                        ph_d      = '0;
                        budget_d  = cycle_budget;
                        mask_d    = '0;
                        count_d   = '0;
                        timeout_d = 1'b0;
                    end
                end
                HOLD: begin
                    if (ph_cnt == PH_W'(RST_HOLD - 1)) begin
                        state_d = RELEASE;
                        ph_d    = '0;
                    end else begin
                        ph_d = ph_cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (ph_cnt == PH_W'(REL_LEN - 1)) begin
                        state_d = RUN;
                        ph_d    = '0;
                    end else begin
                        ph_d = ph_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (cycle_count != '1) begin
                        count_d = cycle_count + 1'b1;
                    end
                    // Completion uses the registered mask, so it lags the
                    // last halt by one cycle and loses to a same-edge expiry.
                    if (&halted_mask) begin
                        state_d = DONE;
                    end else if (budget != '0 &&
                                 cycle_count + CYCLE_W'(1) == budget) begin
                        state_d   = DONE;
                        timeout_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Outputs are registered, so derive them from the next state.
        core_rst_d = '1;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (state_d == RELEASE) begin
                core_rst_d[i] = (int'(ph_d) < i * STAGGER);
            end else if (state_d == RUN) begin
                core_rst_d[i] = 1'b0;
            end
        end
        running_d = (state_d == RELEASE) || (state_d == RUN);
        done_d    = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ph_cnt      <= '0;
            budget      <= '0;
            core_rst    <= '1;
            running     <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            halted_mask <= '0;
            cycle_count <= '0;
        end else begin
            state       <= state_d;
            ph_cnt      <= ph_d;
            budget      <= budget_d;
            core_rst    <= core_rst_d;
            running     <= running_d;
            done        <= done_d;
            timeout     <= timeout_d;
            halted_mask <= mask_d;
            cycle_count <= count_d;
        end
    end

endmodule

// File: tb/tb_multicore_run_ctrl.sv
// Self-checking bench for multicore_run_ctrl: vector table, directed
// corner sequences, and random stimulus against a timeline model.
module tb_multicore_run_ctrl;

    localparam int N = 4;
    localparam int H = 2;
    localparam int S = 1;
    localparam int L = (N - 1) * S + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] budget = '0;
    logic [3:0]  halted = '0;
    logic [3:0]  core_rst;
    logic        running, done, timeout;
    logic [3:0]  halted_mask;
    logic [31:0] cycle_count;

    logic        start2 = 1'b0;
    logic        abort2 = 1'b0;
    logic [31:0] budget2 = '0;
    logic [1:0]  halted2 = '0;
    logic [1:0]  core_rst2;
    logic        running2, done2, timeout2;
    logic [1:0]  mask2;
    logic [31:0] count2;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    multicore_run_ctrl #(.NUM_CORES(4), .RST_HOLD(2), .STAGGER(1),
                         .CYCLE_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cycle_budget(budget), .core_halted(halted),
        .core_rst(core_rst), .running(running), .done(done),
        .timeout(timeout), .halted_mask(halted_mask),
        .cycle_count(cycle_count)
    );

    multicore_run_ctrl #(.NUM_CORES(2), .RST_HOLD(2), .STAGGER(0),
                         .CYCLE_W(32)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2),
        .cycle_budget(budget2), .core_halted(halted2),
        .core_rst(core_rst2), .running(running2), .done(done2),
        .timeout(timeout2), .halted_mask(mask2),
        .cycle_count(count2)
    );

    typedef struct {
        logic        start;
        logic        abort;
        logic [31:0] budget;
        logic [3:0]  halted;
        logic [3:0]  e_rst;
        logic        e_run;
        logic        e_done;
        logic        e_to;
        logic [3:0]  e_mask;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t tbl[20];

    function automatic vec_t mk(logic st, logic ab, logic [31:0] bu,
                                logic [3:0] ha, logic [3:0] er,
                                logic eru, logic ed, logic et,
                                logic [3:0] em, logic [31:0] ec);
        vec_t v;
        v.start = st; v.abort = ab; v.budget = bu; v.halted = ha;
        v.e_rst = er; v.e_run = eru; v.e_done = ed; v.e_to = et;
        v.e_mask = em; v.e_cnt = ec;
        return v;
    endfunction

    function automatic logic [63:0] outs();
        return {21'b0, core_rst, running, done, timeout,
                halted_mask, cycle_count};
    endfunction

    function automatic logic [63:0] pk(logic [3:0] r, logic ru, logic d,
                                       logic t, logic [3:0] m,
                                       logic [31:0] c);
        return {21'b0, r, ru, d, t, m, c};
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a run is a timeline t cycles after the accepted
    // start; the phase and released cores follow from t arithmetically.
    bit          m_active, m_fin, m_to;
    int          m_t;
    logic [3:0]  m_mask;
    logic [31:0] m_count, m_budget;

    function automatic logic [3:0] m_crst();
        logic [3:0] r = '1;
        for (int i = 0; i < N; i++)
            if (m_active && m_t >= H && (m_t - H) >= i * S) r[i] = 1'b0;
        return r;
    endfunction

    function automatic logic [63:0] m_out();
        return pk(m_crst(), m_active && m_t >= H, m_fin, m_to,
                  m_mask, m_count);
    endfunction

    task automatic m_clear();
        m_active = 0; m_fin = 0; m_to = 0; m_t = 0;
        m_mask = '0; m_count = '0;
    endtask

    task automatic m_step(logic r, logic st, logic ab, logic [31:0] bu,
                          logic [3:0] ha);
        logic [3:0] nm;
        nm = m_mask | (ha & ~m_crst());
        if (r || ab) begin
            m_clear();
        end else if (!m_active && st) begin
            m_clear();
            m_active = 1; m_budget = bu;
        end else begin
            if (m_active && m_t >= H + L) begin
                if (m_count != 32'hFFFF_FFFF) m_count++;
                if (&m_mask) begin
                    m_active = 0; m_fin = 1;
                end else if (m_budget != 0 && m_count == m_budget) begin
                    m_active = 0; m_fin = 1; m_to = 1;
                end
            end
            if (m_active) m_t++;
            m_mask = nm;
        end
    endtask

    localparam logic [63:0] IDLE_OUT = {21'b0, 4'hF, 3'b000, 4'h0, 32'd0};

    initial begin
        tbl[0]  = mk(1, 0, 100, 4'h0, 4'hF, 0, 0, 0, 4'h0, 0);
        tbl[1]  = mk(0, 0, 100, 4'h8, 4'hF, 0, 0, 0, 4'h0, 0);
        tbl[2]  = mk(0, 0, 0,   4'hF, 4'hE, 1, 0, 0, 4'h0, 0);
        tbl[3]  = mk(0, 0, 0,   4'hF, 4'hC, 1, 0, 0, 4'h1, 0);
        tbl[4]  = mk(0, 0, 0,   4'hF, 4'h8, 1, 0, 0, 4'h3, 0);
        tbl[5]  = mk(0, 0, 0,   4'hF, 4'h0, 1, 0, 0, 4'h7, 0);
        tbl[6]  = mk(0, 0, 0,   4'hF, 4'h0, 1, 0, 0, 4'hF, 0);
        tbl[7]  = mk(0, 0, 0,   4'hF, 4'hF, 0, 1, 0, 4'hF, 1);
        tbl[8]  = mk(0, 0, 0,   4'h0, 4'hF, 0, 1, 0, 4'hF, 1);
        tbl[9]  = mk(1, 1, 0,   4'h0, 4'hF, 0, 0, 0, 4'h0, 0);
        tbl[10] = mk(1, 0, 3,   4'h0, 4'hF, 0, 0, 0, 4'h0, 0);
        tbl[11] = mk(0, 0, 0,   4'h0, 4'hF, 0, 0, 0, 4'h0, 0);
        tbl[12] = mk(0, 0, 0,   4'h0, 4'hE, 1, 0, 0, 4'h0, 0);
        tbl[13] = mk(0, 0, 0,   4'h0, 4'hC, 1, 0, 0, 4'h0, 0);
        tbl[14] = mk(0, 0, 0,   4'h0, 4'h8, 1, 0, 0, 4'h0, 0);
        tbl[15] = mk(0, 0, 0,   4'h0, 4'h0, 1, 0, 0, 4'h0, 0);
        tbl[16] = mk(0, 0, 0,   4'h0, 4'h0, 1, 0, 0, 4'h0, 0);
        tbl[17] = mk(1, 0, 0,   4'h0, 4'h0, 1, 0, 0, 4'h0, 1);
        tbl[18] = mk(0, 0, 0,   4'h0, 4'h0, 1, 0, 0, 4'h0, 2);
        tbl[19] = mk(0, 0, 0,   4'h0, 4'hF, 0, 1, 1, 4'h0, 3);

        rst = 1'b1;
        tick();
        tick();
        check("reset", outs(), IDLE_OUT);
        check("reset2", {30'b0, core_rst2, running2, done2, mask2, count2},
              {30'b0, 2'b11, 2'b00, 2'b00, 32'd0});
        rst = 1'b0;

        foreach (tbl[i]) begin
            start = tbl[i].start; abort = tbl[i].abort;
            budget = tbl[i].budget; halted = tbl[i].halted;
            tick();
            check($sformatf("vec%0d", i), outs(),
                  pk(tbl[i].e_rst, tbl[i].e_run, tbl[i].e_done,
                     tbl[i].e_to, tbl[i].e_mask, tbl[i].e_cnt));
        end
        start = 0; abort = 0; halted = '0;

        // Basic run from DONE: halts sampled at edge k+20.
        start = 1; budget = 100;
        tick();
        start = 0;
        repeat (19) tick();
        halted = 4'hF;
        tick();
        check("basic_mask", outs(), pk(4'h0, 1, 0, 0, 4'hF, 14));
        tick();
        check("basic_done", outs(), pk(4'hF, 0, 1, 0, 4'hF, 15));
        halted = '0;

        // Unlimited budget restarted from DONE.
        start = 1; budget = 0;
        tick();
        start = 0;
        repeat (306) tick();
        check("unlimited", outs(), pk(4'h0, 1, 0, 0, 4'h0, 300));

        // Abort in RUN at cycle_count 5.
        abort = 1;
        tick();
        abort = 0;
        start = 1; budget = 50;
        tick();
        start = 0;
        repeat (11) tick();
        check("pre_abort", outs(), pk(4'h0, 1, 0, 0, 4'h0, 5));
        abort = 1;
        tick();
        abort = 0;
        check("abort_run", outs(), IDLE_OUT);

        // Synchronous reset in the middle of RELEASE.
        start = 1;
        tick();
        start = 0;
        tick();
        tick();
        check("mid_release", outs(), pk(4'hE, 1, 0, 0, 4'h0, 0));
        rst = 1;
        tick();
        rst = 0;
        check("rst_release", outs(), IDLE_OUT);

        // Zero stagger on the two-core instance.
        start2 = 1;
        tick();
        start2 = 0;
        tick();
        check("s0_hold", {62'b0, core_rst2}, 64'd3);
        tick();
        check("s0_rel", {61'b0, core_rst2, running2}, 64'd1);
        tick();
        tick();
        check("s0_run", {29'b0, core_rst2, running2, done2, count2},
              {29'b0, 2'b00, 1'b1, 1'b0, 32'd1});

        // Random stimulus against the timeline model.
        rst = 1;
        m_step(1, 0, 0, 0, 0);
        tick();
        rst = 0;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(399) == 0);
            start = ($urandom_range(9) == 0);
            abort = ($urandom_range(149) == 0);
            budget = ($urandom_range(3) == 0) ? 32'd0 :
                     32'($urandom_range(40, 1));
            for (int b = 0; b < N; b++)
                halted[b] = ($urandom_range(5) == 0);
            m_step(rst, start, abort, budget, halted);
            tick();
            check($sformatf("rand%0d", c), outs(), m_out());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
